fini_and_check: RTL and testbench

FINI_AND_CHECK -- requirements
Module: fini_and_check

---
 rtl/fini_pkg.sv | 13 +
 rtl/fini_and_ref.sv | 18 +
 rtl/fini_and_check.sv | 126 ++++++++++++
 tb/tb_fini_and_check.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fini_pkg.sv
// Shared definitions for the AND-result checker: FSM states and default sizing.
package fini_pkg;

  localparam int FINI_WIDTH  = 5;
  localparam int FINI_CNT_W  = 8;
  localparam int FINI_THRESH = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } fini_state_e;

endpackage

// File: rtl/fini_and_ref.sv
// Combinational reference AND: recomputes a & b and compares it with the claimed result c.
module fini_and_ref #(
  parameter int WIDTH = fini_pkg::FINI_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] syndrome,
  output logic             fault
);

  logic [WIDTH-1:0] w_ref;

  assign w_ref    = a & b;
  assign syndrome = c ^ w_ref;
  assign fault    = |syndrome;

endmodule

// File: rtl/fini_and_check.sv
// Checker for a protected AND datapath: registers a verdict per accepted triple,
// counts faulty verdicts and locks the input side once the count reaches THRESH.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_RUN    | triples accepted whenever the output register can take one
//   ST_LOCKED | fault threshold reached; inputs refused until clear
module fini_and_check
  import fini_pkg::*;
#(
  parameter int WIDTH  = FINI_WIDTH,
  parameter int CNT_W  = FINI_CNT_W,
  parameter int THRESH = FINI_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic [WIDTH-1:0] port_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fault,
  output logic [WIDTH-1:0] syndrome,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             locked,
  input  logic             clear
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  fini_state_e      r_state;
  fini_state_e      w_state_nxt;
  logic             r_out_valid;
  logic             r_fault;
  logic [WIDTH-1:0] r_syndrome;
  logic [CNT_W-1:0] r_fault_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [WIDTH-1:0] w_syndrome;
  logic             w_fault;
  logic             w_locked;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_pop;
  logic             w_cnt_inc;

  fini_and_ref #(
    .WIDTH (WIDTH)
  ) u_and_ref (
    .a        (port_a),
    .b        (port_b),
    .c        (port_c),
    .syndrome (w_syndrome),
    .fault    (w_fault)
  );

  assign w_locked   = (r_state == ST_LOCKED);
  assign w_in_ready = (!r_out_valid || out_ready) && !w_locked;
  assign w_xfer     = in_valid && w_in_ready;
  assign w_pop      = r_out_valid && out_ready;

  // clear takes priority over a simultaneous faulty transfer
  assign w_cnt_inc  = w_xfer && w_fault && !clear && (r_fault_cnt != CNT_MAX);

  always_comb begin
    w_cnt_nxt = r_fault_cnt;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (w_cnt_inc) begin
      w_cnt_nxt = r_fault_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (!clear && w_xfer && w_fault && (w_cnt_nxt >= THRESH_C)) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (clear) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_fault_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fault_cnt <= w_cnt_nxt;
    end
  end

  // Single-entry verdict register; a pop and a new transfer may share one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_syndrome  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_fault     <= w_fault;
      r_syndrome  <= w_syndrome;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign fault     = r_fault;
  assign syndrome  = r_syndrome;
  assign fault_cnt = r_fault_cnt;
  assign locked    = w_locked;

endmodule

// File: tb/tb_fini_and_check.sv
// Directed plus random checks of fini_and_check against a transaction-level model.
module tb_fini_and_check;

  localparam int WIDTH  = 5;
  localparam int CNT_W  = 2;
  localparam int THRESH = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] port_a, port_b, port_c;
  logic             out_valid;
  logic             out_ready;
  logic             fault;
  logic [WIDTH-1:0] syndrome;
  logic [CNT_W-1:0] fault_cnt;
  logic             locked;
  logic             clear;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit       m_ov;
  bit       m_fault;
  bit [4:0] m_syn;
  int       m_cnt;
  bit       m_lock;

  fini_and_check #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .port_a    (port_a),
    .port_b    (port_b),
    .port_c    (port_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fault     (fault),
    .syndrome  (syndrome),
    .fault_cnt (fault_cnt),
    .locked    (locked),
    .clear     (clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_fault = 0; m_syn = '0; m_cnt = 0; m_lock = 0;
  endtask

  task automatic chk_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk("fault", {31'd0, fault}, {31'd0, m_fault});
      chk("syndrome", {27'd0, syndrome}, {27'd0, m_syn});
    end
    chk("fault_cnt", {30'd0, fault_cnt}, m_cnt);
    chk("locked", {31'd0, locked}, {31'd0, m_lock});
  endtask

  // One clock cycle: drive, check in_ready, advance model at the edge, check outputs.
  task automatic step(input bit iv, input bit [4:0] a, input bit [4:0] b, input bit [4:0] c,
                      input bit ordy, input bit clr);
    bit       rdy, xfer;
    bit [4:0] syn;
    @(negedge clk);
    in_valid = iv; port_a = a; port_b = b; port_c = c; out_ready = ordy; clear = clr;
    rdy = (!m_ov || ordy) && !m_lock;
    #1 chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    xfer = iv && rdy;
    syn  = c ^ (a & b);
    if (xfer) begin
      m_ov = 1; m_syn = syn; m_fault = (syn != 0);
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
    if (clr) begin
      m_cnt = 0; m_lock = 0;
    end else if (xfer && syn != 0) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_cnt >= THRESH) m_lock = 1;
    end
    #1 chk_outputs();
  endtask

  initial begin
    rst_n = 0; in_valid = 0; port_a = '0; port_b = '0; port_c = '0;
    out_ready = 0; clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_fault_cnt", {30'd0, fault_cnt}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    @(negedge clk);
    rst_n = 1;

    // golden transfer
    step(1, 5'h1F, 5'h0A, 5'h0A, 1, 0);
    chk("golden_valid", {31'd0, out_valid}, 1);
    chk("golden_fault", {31'd0, fault}, 0);
    chk("golden_syn", {27'd0, syndrome}, 32'h00);

    // single-bit fault
    step(1, 5'h1F, 5'h0A, 5'h0B, 1, 0);
    chk("sbf_fault", {31'd0, fault}, 1);
    chk("sbf_syn", {27'd0, syndrome}, 32'h01);
    chk("sbf_cnt", {30'd0, fault_cnt}, 1);

    // backpressure: verdict held, then pop and accept on one edge
    repeat (3) step(1, 5'h03, 5'h05, 5'h10, 0, 0);
    chk("bp_syn_hold", {27'd0, syndrome}, 32'h01);
    step(1, 5'h1F, 5'h0A, 5'h0A, 1, 0);
    chk("bp_accept_fault", {31'd0, fault}, 0);

    // lock after three back-to-back faults
    step(0, 5'h00, 5'h00, 5'h00, 1, 1);
    repeat (3) step(1, 5'h1F, 5'h1F, 5'h00, 1, 0);
    chk("lock_cnt", {30'd0, fault_cnt}, 3);
    chk("lock_locked", {31'd0, locked}, 1);
    chk("lock_in_ready", {31'd0, in_ready}, 0);
    step(1, 5'h01, 5'h01, 5'h00, 0, 0);
    step(0, 5'h00, 5'h00, 5'h00, 1, 0);
    step(0, 5'h00, 5'h00, 5'h00, 1, 1);
    chk("unlock_locked", {31'd0, locked}, 0);
    chk("unlock_cnt", {30'd0, fault_cnt}, 0);

    // saturation: four faults, counter stays at its maximum
    repeat (4) step(1, 5'h0F, 5'h0F, 5'h1F, 1, 0);
    chk("sat_cnt", {30'd0, fault_cnt}, 3);
    step(0, 5'h00, 5'h00, 5'h00, 1, 1);

    // clear wins over a simultaneous faulty transfer
    step(1, 5'h01, 5'h01, 5'h00, 1, 0);
    step(1, 5'h1F, 5'h1F, 5'h00, 1, 1);
    chk("clr_win_cnt", {30'd0, fault_cnt}, 0);
    chk("clr_win_syn", {27'd0, syndrome}, 32'h1F);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bit [4:0] a, b, c;
      a = 5'($urandom);
      b = 5'($urandom);
      c = ($urandom_range(0, 1) == 1) ? (a & b) : 5'($urandom);
      step($urandom_range(0, 3) != 0, a, b, c, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    // reset mid-stream with a pending verdict
    step(1, 5'h1F, 5'h0A, 5'h0B, 0, 1);
    step(0, 5'h00, 5'h00, 5'h00, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 0);
    chk("mrst_fault", {31'd0, fault}, 0);
    chk("mrst_syn", {27'd0, syndrome}, 0);
    chk("mrst_cnt", {30'd0, fault_cnt}, 0);
    chk("mrst_locked", {31'd0, locked}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step(1, 5'h15, 5'h0F, 5'h05, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
